// File: rtl/mem_rw_arbiter_if.sv
// Requester-side request/response bundle plus the MemRWHelper port pair for mem_rw_arbiter.
// The slave modport is the arbiter's view; master is the requesters-plus-memory side.
interface mem_rw_arbiter_if #(
  parameter int NUM_REQ = 2
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ-1:0]    req_write;
  logic [NUM_REQ*64-1:0] req_addr;
  logic [NUM_REQ*64-1:0] req_wdata;
  logic [NUM_REQ*64-1:0] req_wmask;
  logic [NUM_REQ-1:0]    resp_valid;
  logic [NUM_REQ-1:0]    resp_ready;
  logic [63:0]           resp_rdata;
  logic                  resp_err;
  logic                  mem_enable;
  logic                  mem_r_enable;
  logic [63:0]           mem_r_index;
  logic [63:0]           mem_r_data;
  logic                  mem_w_enable;
  logic [63:0]           mem_w_index;
  logic [63:0]           mem_w_data;
  logic [63:0]           mem_w_mask;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_wmask, resp_ready, mem_r_data,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_enable, mem_r_enable, mem_r_index, mem_w_enable, mem_w_index, mem_w_data, mem_w_mask
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_wmask, resp_ready, mem_r_data,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_enable, mem_r_enable, mem_r_index, mem_w_enable, mem_w_index, mem_w_data, mem_w_mask
  );
endinterface

// File: rtl/mem_rw_arbiter.sv
// Round-robin arbiter sharing one word-indexed memory port among NUM_REQ byte-addressed requesters.
// One transaction in flight; read/write/error responses at +3/+2/+1 cycles, held until resp_ready.
module mem_rw_arbiter #(
  parameter int          NUM_REQ   = 2,
  parameter logic [63:0] BASE_ADDR = 64'h0000_0000_8000_0000,
  parameter logic [63:0] RAM_SIZE  = 64'h0000_0000_8000_0000
) (
  input logic             clock,
  input logic             reset_n,
  mem_rw_arbiter_if.slave bus
);
  localparam int          IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [63:0] END_ADDR = BASE_ADDR + RAM_SIZE;

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] rr_ptr, grant, owner, cand;
  logic             gnt_vld;
  logic             wr_q, err_q;
  logic [63:0]      index_q, wdata_q, wmask_q, rdata_q;
  logic [63:0]      acc_addr, acc_index;
  logic             acc_err;

  logic [63:0] addr_a  [NUM_REQ];
  logic [63:0] wdata_a [NUM_REQ];
  logic [63:0] wmask_a [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_req
    assign addr_a[g]  = bus.req_addr[g*64 +: 64];
    assign wdata_a[g] = bus.req_wdata[g*64 +: 64];
    assign wmask_a[g] = bus.req_wmask[g*64 +: 64];
  end

  // Scan from the highest offset down so the requester closest to rr_ptr wins.
  always_comb begin
    gnt_vld = 1'b0;
    grant   = '0;
    cand    = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = IDX_W'((int'(rr_ptr) + i) % NUM_REQ);
      if (bus.req_valid[cand]) begin
        gnt_vld = 1'b1;
        grant   = cand;
      end
    end
  end

  assign acc_addr  = addr_a[grant];
  assign acc_err   = (acc_addr < BASE_ADDR) || (acc_addr >= END_ADDR);
  assign acc_index = (acc_addr - BASE_ADDR) >> 3;

  always_comb begin
    state_nxt        = state;
    bus.req_ready    = '0;
    bus.resp_valid   = '0;
    bus.resp_rdata   = '0;
    bus.resp_err     = 1'b0;
    bus.mem_enable   = 1'b0;
    bus.mem_r_enable = 1'b0;
    bus.mem_r_index  = '0;
    bus.mem_w_enable = 1'b0;
    bus.mem_w_index  = '0;
    bus.mem_w_data   = '0;
    bus.mem_w_mask   = '0;
    case (state)
      IDLE: begin
        if (gnt_vld && reset_n) begin
          bus.req_ready[grant] = 1'b1;
          state_nxt = acc_err ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        bus.mem_enable = 1'b1;
        if (wr_q) begin
          bus.mem_w_enable = 1'b1;
          bus.mem_w_index  = index_q;
          bus.mem_w_data   = wdata_q;
          bus.mem_w_mask   = wmask_q;
          state_nxt        = RESP;
        end else begin
          bus.mem_r_enable = 1'b1;
          bus.mem_r_index  = index_q;
          state_nxt        = CAPTURE;
        end
      end
      CAPTURE: state_nxt = RESP;
      RESP: begin
        bus.resp_valid[owner] = 1'b1;
        bus.resp_rdata        = rdata_q;
        bus.resp_err          = err_q;
        if (bus.resp_ready[owner]) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      owner   <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      index_q <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
      rdata_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && gnt_vld) begin
        owner   <= grant;
        rr_ptr  <= (grant == IDX_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
        wr_q    <= bus.req_write[grant];
        err_q   <= acc_err;
        index_q <= acc_index;
        wdata_q <= wdata_a[grant];
        wmask_q <= wmask_a[grant];
        rdata_q <= '0;
      end else if (state == CAPTURE) begin
        rdata_q <= bus.mem_r_data;
      end
    end
  end
endmodule
